// File: rtl/dtpu_csr_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : dtpu_csr_ctrl_if
// Description : Host register bus, CU CSR read port and start/done handshake
//               between the PS and the DTPU control unit.
// Revision    : 1.0
// ============================================================================
interface dtpu_csr_ctrl_if #(
    parameter int DATA_WIDTH_CSR   = 8,
    parameter int ADDRESS_SIZE_CSR = 32
);
    logic                        host_wr;
    logic                        host_rd;
    logic [ADDRESS_SIZE_CSR-1:0] host_addr;
    logic [DATA_WIDTH_CSR-1:0]   host_wdata;
    logic [DATA_WIDTH_CSR-1:0]   host_rdata;
    logic                        host_rvalid;

    logic                        csr_ce;
    logic                        csr_we;
    logic [ADDRESS_SIZE_CSR-1:0] csr_address;
    logic                        csr_reset;
    logic [DATA_WIDTH_CSR-1:0]   csr_dout;

    logic                        cs_start;
    logic                        cs_continue;
    logic                        cs_ready;
    logic                        cs_done;
    logic                        cs_idle;
    logic                        irq;

    modport master (
        output host_wr, host_rd, host_addr, host_wdata,
        output csr_ce, csr_we, csr_address, csr_reset,
        output cs_ready, cs_done, cs_idle,
        input  host_rdata, host_rvalid, csr_dout,
        input  cs_start, cs_continue, irq
    );

    modport slave (
        input  host_wr, host_rd, host_addr, host_wdata,
        input  csr_ce, csr_we, csr_address, csr_reset,
        input  cs_ready, cs_done, cs_idle,
        output host_rdata, host_rvalid, csr_dout,
        output cs_start, cs_continue, irq
    );
endinterface
`default_nettype wire

// File: rtl/dtpu_csr_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : dtpu_csr_ctrl
// Description : CSR bank and host-side start/ready/done responder for the
//               DTPU control unit, with level interrupt on ready/done.
// Revision    : 1.0
// ============================================================================
module dtpu_csr_ctrl #(
    parameter int DATA_WIDTH_CSR   = 8,
    parameter int ADDRESS_SIZE_CSR = 32,
    parameter int NUM_CSR          = 16
) (
    input  wire logic           clk,
    input  wire logic           reset,
    dtpu_csr_ctrl_if.slave      bus
);
    localparam logic [3:0] c_ADDR_CTRL = 4'h0;
    localparam logic [3:0] c_ADDR_GIE  = 4'h1;
    localparam logic [3:0] c_ADDR_IER  = 4'h2;
    localparam logic [3:0] c_ADDR_ISR  = 4'h3;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ARMED = 2'd1,
        S_RUN   = 2'd2
    } state_t;

    state_t                    r_state;
    logic                      r_cs_start;
    logic                      r_cs_continue;
    logic                      r_ap_done;
    logic                      r_ap_ready;
    logic                      r_auto_restart;
    logic                      r_gie;
    logic [1:0]                r_ier;
    logic [1:0]                r_isr;
    logic [DATA_WIDTH_CSR-1:0] r_cfg [4:NUM_CSR-1];
    logic [DATA_WIDTH_CSR-1:0] r_host_rdata;
    logic                      r_host_rvalid;
    logic [DATA_WIDTH_CSR-1:0] r_csr_dout;

    logic [3:0]                w_host_idx;
    logic [3:0]                w_cu_idx;
    logic                      w_wr_ctrl;
    logic                      w_wr_isr;
    logic                      w_rd_ctrl;
    logic                      w_start;
    logic                      w_ready_ev;
    logic                      w_done_ev;
    logic [DATA_WIDTH_CSR-1:0] w_view [16];
    logic                      w_unused;

    assign w_host_idx = bus.host_addr[3:0];
    assign w_cu_idx   = bus.csr_address[3:0];
    assign w_wr_ctrl  = bus.host_wr && (w_host_idx == c_ADDR_CTRL);
    assign w_wr_isr   = bus.host_wr && (w_host_idx == c_ADDR_ISR);
    assign w_rd_ctrl  = bus.host_rd && (w_host_idx == c_ADDR_CTRL);
    assign w_start    = w_wr_ctrl && bus.host_wdata[0] && (r_state == S_IDLE);
    assign w_ready_ev = bus.cs_ready && (r_state == S_ARMED);
    assign w_done_ev  = bus.cs_done && (r_state == S_RUN);
    assign w_unused   = ^{bus.csr_we, bus.host_addr[ADDRESS_SIZE_CSR-1:4],
                          bus.csr_address[ADDRESS_SIZE_CSR-1:4]};

    // Unified read view; slots at or beyond NUM_CSR stay zero.
    always_comb begin
        for (int i = 0; i < 16; i++) begin
            w_view[i] = '0;
        end
        w_view[0][0] = r_cs_start;
        w_view[0][1] = r_ap_done;
        w_view[0][2] = bus.cs_idle;
        w_view[0][3] = r_ap_ready;
        w_view[0][7] = r_auto_restart;
        w_view[1][0] = r_gie;
        w_view[2][1:0] = r_ier;
        w_view[3][1:0] = r_isr;
        for (int i = 4; i < NUM_CSR && i < 16; i++) begin
            w_view[i] = r_cfg[i];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state    <= S_IDLE;
            r_cs_start <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: if (w_start) begin
                    r_state    <= S_ARMED;
                    r_cs_start <= 1'b1;
                end
                S_ARMED: if (w_ready_ev) begin
                    r_state    <= S_RUN;
                    r_cs_start <= 1'b0;
                end
                S_RUN: if (w_done_ev) begin
                    r_state    <= r_auto_restart ? S_ARMED : S_IDLE;
                    r_cs_start <= r_auto_restart;
                end
                default: begin
                    r_state    <= S_IDLE;
                    r_cs_start <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_cs_continue  <= 1'b0;
            r_ap_done      <= 1'b0;
            r_ap_ready     <= 1'b0;
            r_auto_restart <= 1'b0;
            r_gie          <= 1'b0;
            r_ier          <= 2'b00;
            r_isr          <= 2'b00;
            r_host_rdata   <= '0;
            r_host_rvalid  <= 1'b0;
            r_csr_dout     <= '0;
            for (int i = 4; i < NUM_CSR; i++) begin
                r_cfg[i] <= '0;
            end
        end else begin
            r_host_rvalid <= bus.host_rd;
            if (bus.host_rd) begin
                r_host_rdata <= w_view[w_host_idx];
            end
            if (bus.csr_ce) begin
                r_csr_dout <= w_view[w_cu_idx];
            end
            r_cs_continue <= w_wr_ctrl && bus.host_wdata[4];

            // A status event in the same cycle as its clear always wins.
            r_ap_ready <= w_ready_ev | (r_ap_ready & ~w_rd_ctrl);
            r_ap_done  <= w_done_ev  | (r_ap_done  & ~w_rd_ctrl);
            r_isr[0]   <= (w_done_ev  & r_ier[0]) | (r_isr[0] & ~(w_wr_isr & bus.host_wdata[0]));
            r_isr[1]   <= (w_ready_ev & r_ier[1]) | (r_isr[1] & ~(w_wr_isr & bus.host_wdata[1]));

            if (w_wr_ctrl) begin
                r_auto_restart <= bus.host_wdata[7];
            end
            if (bus.host_wr && (w_host_idx == c_ADDR_GIE)) begin
                r_gie <= bus.host_wdata[0];
            end
            if (bus.host_wr && (w_host_idx == c_ADDR_IER)) begin
                r_ier <= bus.host_wdata[1:0];
            end
            for (int i = 4; i < NUM_CSR; i++) begin
                if (bus.csr_reset) begin
                    r_cfg[i] <= '0;
                end else if (bus.host_wr && (w_host_idx == 4'(i))) begin
                    r_cfg[i] <= bus.host_wdata;
                end
            end
        end
    end

    assign bus.host_rdata  = r_host_rdata;
    assign bus.host_rvalid = r_host_rvalid;
    assign bus.csr_dout    = r_csr_dout;
    assign bus.cs_start    = r_cs_start;
    assign bus.cs_continue = r_cs_continue;
    assign bus.irq         = r_gie & (|r_isr);
endmodule
`default_nettype wire

// File: doc/dtpu_csr_ctrl.md
# dtpu_csr_ctrl

Host-facing control/status responder for the DTPU. It holds the CSR bank that `control_unit` reads through its `csr_*` port, and it drives the other end of the `cs_start`/`cs_ready`/`cs_done`/`cs_idle`/`cs_continue` handshake from PS register writes. It also raises a level interrupt on ready/done. It sits between the PS register bus and the DTPU control unit.

## Interface
- DATA_WIDTH_CSR, 8, CSR word width (host and CU side).
- ADDRESS_SIZE_CSR, 32, CSR address width; only bits [3:0] are decoded.
- NUM_CSR, 16, number of CSR words; addresses ≥ NUM_CSR read 0 and ignore writes.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-low.
- host_wr  in  1  host write strobe, one cycle per access.
- host_rd  in  1  host read strobe; host_wr and host_rd are never both high.
- host_addr  in  ADDRESS_SIZE_CSR  host word address.
- host_wdata  in  DATA_WIDTH_CSR  write data.
- host_rdata  out  DATA_WIDTH_CSR  read data, registered.
- host_rvalid  out  1  one-cycle pulse, one cycle after host_rd.
- csr_ce  in  1  CU read enable.
- csr_we  in  1  CU write enable (CU never writes; ignored).
- csr_address  in  ADDRESS_SIZE_CSR  CU read address.
- csr_reset  in  1  CU request to clear the configuration registers.
- csr_dout  out  DATA_WIDTH_CSR  CU read data, registered.
- cs_start  out  1  level start request to the CU.
- cs_continue  out  1  one-cycle continue pulse.
- cs_ready  in  1  CU pulse: start accepted.
- cs_done  in  1  CU pulse: job finished.
- cs_idle  in  1  CU idle level.
- irq  out  1  interrupt level.

## Operation
- Register map:
  - 0x0 CTRL: bit0 ap_start (RW1S), bit1 ap_done (RO, clear-on-read), bit2 ap_idle (RO, mirrors cs_idle), bit3 ap_ready (RO, clear-on-read), bit4 continue (WO, self-clearing), bit7 auto_restart (RW).
  - 0x1 GIE: bit0.
  - 0x2 IER: bit0 done, bit1 ready.
  - 0x3 ISR: bit0 done, bit1 ready; W1C.
  - 0x4 A_ARITHMETIC_PRECISION.
  - 0x5 A_FP_MODE.
  - 0x6–0xF general RW.
  - The csr_definition.vh macros carry these same addresses.
- Handshake FSM: IDLE, ARMED, RUN.
  - IDLE → ARMED when the host writes CTRL with bit0=1. cs_start=1 in ARMED.
  - ARMED → RUN on cs_ready. cs_start drops the next cycle and ap_ready is set.
  - RUN → IDLE on cs_done; ap_done is set. If auto_restart=1, RUN → ARMED instead.
  - Writing bit0=0 never cancels a start. Writing bit0=1 outside IDLE is ignored.
  - cs_ready outside ARMED and cs_done outside RUN are ignored.
- ap_start readback equals cs_start.
- Writing CTRL bit4=1 pulses cs_continue for exactly one cycle, in any state.
- ISR bit sets when the matching event occurs and the matching IER bit is 1. irq = GIE[0] & |ISR[1:0].
- csr_reset clears addresses 0x4–0xF to 0x00. It does not touch CTRL, GIE, IER or ISR.
- Host writes to read-only bits are ignored.

## Timing
- Reset: all outputs 0, FSM in IDLE, all registers 0x00.
- CU read: csr_dout is valid the cycle after csr_ce=1 and holds its value while csr_ce=0.
- Host read: host_rdata/host_rvalid arrive one cycle after host_rd.
- Clear-on-read takes effect in the cycle after the read.
- Same-cycle host write and CU read of one address: the CU gets the old value.
- Same-cycle status set and clear-on-read (or ISR W1C): set wins. The read returns the pre-update value, and the bit reads 1 next time.
- Same-cycle csr_reset and host write to 0x4–0xF: csr_reset wins.
- cs_start asserts the cycle after the start write.
- Reset asserted mid-job returns the FSM to IDLE and clears all outputs and registers.

## Test plan
- Reset, then read every address: all 0x00. Outputs 0 except host_rvalid pulses.
- Write 0x4=0x13, 0x5=0x02. CU reads 0x4 then 0x5 back-to-back: csr_dout is 0x13 then 0x02, each one cycle after its csr_ce. Pulse csr_reset: both read 0x00; GIE unchanged.
- Write GIE=1, IER=3, CTRL=0x01. Check cs_start=1 until cs_ready; ISR=0x2 and irq=1. Then cs_done: ISR=0x3 and the FSM is IDLE. First CTRL read shows bit1 set; second shows it clear. Write ISR=0x3: irq=0.
- auto_restart: CTRL=0x81, then ready and done. cs_start re-asserts the cycle after cs_done; three jobs complete with no further writes.
- Same-cycle cs_done and host read of CTRL: the read shows done=0, the next read shows done=1.
- Stray cs_ready in IDLE produces no state change. CTRL write 0x10 gives a single-cycle cs_continue. Reset asserted in ARMED drops cs_start on the next edge.
